detect_window_counter: RTL and testbench

- Sits directly downstream of the multi-stream sequence detector and consumes its registered detection flag z.
- Counts detection events inside back-to-back, programmable-length observation windows.
- Each completed or aborted window produces one result record, pushed into a small first-word-fall-through FIFO.
- Results are drained by the host side through a valid/ready handshake.

---
 rtl/detect_window_counter.sv | 183 ++++++++++++++++++
 tb/tb_detect_window_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/detect_window_counter.sv
// detect_window_counter
//   Counts detection events from the upstream sequence detector inside
//   back-to-back, programmable-length observation windows. Each finished or
//   aborted window emits one record {partial, overflow, count} into a small
//   first-word-fall-through FIFO that the host drains with valid/ready.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   z_in         detection flag (launched on the falling edge of clk)
//   enable       1 = run windows continuously, 0 = stop / abort
//   win_len      window length in cycles, latched at window start (0 -> 1)
//   res_valid    FIFO not empty
//   res_ready    consumer accepts the head record
//   res_count    head record event count
//   res_overflow head record saturated (events were lost)
//   res_partial  head record came from an aborted window
//   fifo_drop    one-cycle pulse: a record was discarded because FIFO full
//   busy         a window is running
//
// Build option
//   LEVEL_COUNT_EN  defined: every cycle with z high is counted (occupancy).
//                   undefined: one event per rising edge of z.

module detect_window_counter #(
  parameter int CNT_W      = 8,
  parameter int WIN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_overflow,
  output logic             res_partial,
  output logic             fifo_drop,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = CNT_W + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             z_q, ev;
  logic [WIN_W-1:0] timer, timer_nxt, len;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             ovf, ovf_nxt, ovf_inc;
  logic             push, part;

  // ---------------- input sampling / event detect ----------------
`ifdef LEVEL_COUNT_EN
  assign ev = z_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) z_q <= 1'b0;
    else       z_q <= z_in;
`else
  logic z_d;
  assign ev = z_q & ~z_d;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      z_q <= 1'b0;
      z_d <= 1'b0;
    end else begin
      z_q <= z_in;
      z_d <= z_q;
    end
`endif

  assign len = (win_len == '0) ? WIN_W'(1) : win_len;

  // count including this cycle's event; saturates and flags overflow
  always_comb begin
    cnt_inc = cnt;
    ovf_inc = ovf;
    if (ev) begin
      if (&cnt) ovf_inc = 1'b1;
      else      cnt_inc = cnt + 1'b1;
    end
  end

  // ---------------- window FSM ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    push      = 1'b0;
    part      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          timer_nxt = len - 1'b1;
          cnt_nxt   = CNT_W'(ev);     // entry-cycle event belongs to the new window
          ovf_nxt   = 1'b0;
        end
      end
      RUN: begin
        cnt_nxt = cnt_inc;
        ovf_nxt = ovf_inc;
        if (timer == '0) begin
          push = 1'b1;
          if (enable) begin           // restart with no gap cycle
            timer_nxt = len - 1'b1;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!enable) begin
          push      = 1'b1;
          part      = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // ---------------- result FIFO (FWFT) ----------------
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   used;
  logic             full, pop, wr_en;
  logic [REC_W-1:0] head;

  assign full      = (used == (PTR_W+1)'(FIFO_DEPTH));
  assign res_valid = (used != '0);
  assign pop       = res_valid & res_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en     = push & (~full | pop);
  assign fifo_drop = push & full & ~pop;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= {part, ovf_inc, cnt_inc};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end

  // storage is not reset, so gate the head to keep outputs 0 when empty
  assign head         = res_valid ? mem[rd_ptr] : '0;
  assign res_count    = head[CNT_W-1:0];
  assign res_overflow = head[CNT_W];
  assign res_partial  = head[CNT_W+1];

endmodule

// File: tb/tb_detect_window_counter.sv
module tb_detect_window_counter;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int DEPTH = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             z_in = 1'b0;
  logic             enable = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             res_valid, res_ready = 1'b0;
  logic [CNT_W-1:0] res_count;
  logic             res_overflow, res_partial, fifo_drop, busy;

  int n_chk = 0, n_fail = 0, n_drop = 0;

  always #5 clk = ~clk;

  detect_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .z_in(z_in), .enable(enable), .win_len(win_len),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_overflow(res_overflow), .res_partial(res_partial),
    .fifo_drop(fifo_drop), .busy(busy)
  );

  // ---------------- reference model ----------------
  // Windows are tracked as "cycles left" plus an unbounded event total;
  // saturation is applied only when a record is formed.
  typedef struct { int cnt; bit ovf; bit part; } rec_t;
  rec_t q[$];
  bit   m_run, m_zq, m_zd;
  int   m_left, m_evn;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int eff_len(input int wl);
    return (wl == 0) ? 1 : wl;
  endfunction

  // Called at a negedge with this cycle's inputs already driven.
  task automatic step();
    bit   ev, push, part, drop;
    int   tot;
    rec_t r;
`ifdef LEVEL_COUNT_EN
    ev = m_zq;
`else
    ev = m_zq & ~m_zd;
`endif
    tot  = m_evn + int'(ev);
    push = 1'b0;
    part = 1'b0;
    if (m_run) begin
      if (m_left == 1) push = 1'b1;
      else if (!enable) begin push = 1'b1; part = 1'b1; end
    end
    drop = push && q.size() == DEPTH && !res_ready;
    #1;
    chk("valid", res_valid, q.size() != 0);
    chk("count", res_count, q.size() != 0 ? q[0].cnt : 0);
    chk("ovf",   res_overflow, q.size() != 0 ? q[0].ovf : 1'b0);
    chk("part",  res_partial,  q.size() != 0 ? q[0].part : 1'b0);
    chk("busy",  busy, m_run);
    chk("drop",  fifo_drop, drop);
    if (fifo_drop) n_drop++;
    @(posedge clk);
    if (q.size() != 0 && res_ready) void'(q.pop_front());
    if (push && q.size() < DEPTH) begin
      r.cnt  = (tot > CMAX) ? CMAX : tot;
      r.ovf  = (tot > CMAX);
      r.part = part;
      q.push_back(r);
    end
    if (!m_run) begin
      if (enable) begin
        m_run  = 1'b1;
        m_left = eff_len(int'(win_len));
        m_evn  = int'(ev);
      end
    end else if (push) begin
      if (!part && enable) begin
        m_left = eff_len(int'(win_len));
        m_evn  = 0;
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_left--;
      m_evn = tot;
    end
    m_zd = m_zq;
    m_zq = z_in;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_count", res_count, 0);
    chk("rst_ovf",   res_overflow, 1'b0);
    chk("rst_part",  res_partial, 1'b0);
    chk("rst_drop",  fifo_drop, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    q.delete();
    m_run = 1'b0; m_left = 0; m_evn = 0; m_zq = 1'b0; m_zd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
    enable = 1'b0; res_ready = 1'b1; z_in = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    do_reset();

    // three single-cycle pulses in a 10-cycle window
    win_len = 10; enable = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      z_in = (i == 2 || i == 5 || i == 8);
      step();
    end
    chk("tp1_count", res_count, 3);
    chk("tp1_part",  res_partial, 1'b0);
    settle();

    // z held for 5 cycles inside an 8-cycle window
    win_len = 8; enable = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      z_in = (i >= 2 && i <= 6);
      step();
    end
`ifdef LEVEL_COUNT_EN
    chk("tp2_count", res_count, 5);
`else
    chk("tp2_count", res_count, 1);
`endif
    settle();

    // 500 rises in a 1000-cycle window saturate the count
    win_len = 1000; enable = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 1002; i++) begin
      z_in = (i % 2 == 1);
      step();
    end
    chk("tp3_count", res_count, CMAX);
    chk("tp3_ovf",   res_overflow, 1'b1);
    settle();

    // abort after 2 events, 4 cycles into a 20-cycle window
    win_len = 20; res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enable = (i < 4);
      z_in   = (i == 0 || i == 2);
      step();
    end
    chk("tp4_count", res_count, 2);
    chk("tp4_part",  res_partial, 1'b1);
    chk("tp4_busy",  busy, 1'b0);
    settle();

    // back-pressure: 4 records held, 2 drops, then pop on a full push
    win_len = 2; enable = 1'b1; res_ready = 1'b0; n_drop = 0;
    repeat (14) step();
    chk("tp5_drops", n_drop, 2);
    res_ready = 1'b1;
    step();
    settle();

    // win_len=0 behaves as 1, then reset in the middle of activity
    win_len = 0; enable = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      z_in = 1'($urandom_range(0, 1));
      step();
    end
    win_len = 30; res_ready = 1'b0;
    repeat (6) step();
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 19) != 0);
      win_len   = WIN_W'($urandom_range(0, 6));
      z_in      = ($urandom_range(0, 2) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
